// File: rtl/wb_master_port_if.sv
// Bundle of request, response and Wishbone signals for wb_master_port.
// The master modport is the view taken by the initiator itself; the slave
// modport is the view of whoever surrounds it (requester and bus slave).
interface wb_master_port_if #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4
);

  // request stream
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [WB_ADDR_WIDTH-1:0] req_addr_i;
  logic [WB_DATA_WIDTH-1:0] req_data_i;
  logic                     req_we_i;
  logic [WB_SEL_WIDTH-1:0]  req_sel_i;

  // response stream
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [WB_DATA_WIDTH-1:0] rsp_data_o;
  logic                     rsp_err_o;

  // Wishbone classic bus
  logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
  logic [WB_DATA_WIDTH-1:0] wb_data_o;
  logic                     wb_we_o;
  logic [WB_SEL_WIDTH-1:0]  wb_sel_o;
  logic                     wb_stb_o;
  logic                     wb_cyc_o;
  logic                     wb_ack_i;
  logic                     wb_err_i;
  logic [WB_DATA_WIDTH-1:0] wb_data_i;

  modport master (
    input  req_valid_i, req_addr_i, req_data_i, req_we_i, req_sel_i,
    output req_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o,
    input  rsp_ready_i,
    output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_ack_i, wb_err_i, wb_data_i
  );

  modport slave (
    output req_valid_i, req_addr_i, req_data_i, req_we_i, req_sel_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o,
    output rsp_ready_i,
    input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_ack_i, wb_err_i, wb_data_i
  );

endinterface

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone classic initiator.
// Accepts one request from a valid/ready stream, runs exactly one Wishbone
// cycle (no bursts, no pipelining) and hands back a valid/ready response.
// Optional bus-wait timeout: define WB_MASTER_TIMEOUT_EN to enable it; when
// undefined the initiator waits indefinitely for ack/err.
module wb_master_port #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_master_port_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Wishbone side registers
  logic [WB_ADDR_WIDTH-1:0] r_wb_addr;
  logic [WB_ADDR_WIDTH-1:0] w_wb_addr_next;
  logic [WB_DATA_WIDTH-1:0] r_wb_data;
  logic [WB_DATA_WIDTH-1:0] w_wb_data_next;
  logic                     r_wb_we;
  logic                     w_wb_we_next;
  logic [WB_SEL_WIDTH-1:0]  r_wb_sel;
  logic [WB_SEL_WIDTH-1:0]  w_wb_sel_next;
  logic                     r_wb_stb;
  logic                     w_wb_stb_next;
  logic                     r_wb_cyc;
  logic                     w_wb_cyc_next;

  // response side registers
  logic                     r_rsp_valid;
  logic                     w_rsp_valid_next;
  logic                     r_rsp_err;
  logic                     w_rsp_err_next;
  logic [WB_DATA_WIDTH-1:0] r_rsp_data;
  logic [WB_DATA_WIDTH-1:0] w_rsp_data_next;

  logic                     w_timeout;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_next;

  // The counter holds the number of completed BUS cycles without ack/err,
  // so reaching TIMEOUT_CYCLES-1 means this is the last allowed cycle.
  assign w_timeout = (r_wait_cnt == CNT_LAST);

  // Wait counter register; cleared by reset so a stale count never leaks
  // into the next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_next;
    end
  end
`else
  // Without the timeout the bus waits forever; keep the parameter referenced
  // so it stays visible in both builds.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  // Ready is purely a function of state: only IDLE can take a request.
  assign bus.req_ready_o = (r_state == S_IDLE);

  assign bus.wb_addr_o   = r_wb_addr;
  assign bus.wb_data_o   = r_wb_data;
  assign bus.wb_we_o     = r_wb_we;
  assign bus.wb_sel_o    = r_wb_sel;
  assign bus.wb_stb_o    = r_wb_stb;
  assign bus.wb_cyc_o    = r_wb_cyc;

  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.rsp_data_o  = r_rsp_data;

  // State and output registers; reset asynchronously drops cyc/stb and
  // discards any transaction or pending response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_wb_we     <= 1'b0;
      r_wb_sel    <= '0;
      r_wb_stb    <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wb_addr   <= w_wb_addr_next;
      r_wb_data   <= w_wb_data_next;
      r_wb_we     <= w_wb_we_next;
      r_wb_sel    <= w_wb_sel_next;
      r_wb_stb    <= w_wb_stb_next;
      r_wb_cyc    <= w_wb_cyc_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_data  <= w_rsp_data_next;
    end
  end

  // Next-state and next-output decode; every register holds unless a
  // transition below says otherwise.
  always_comb begin
    w_state_next     = r_state;
    w_wb_addr_next   = r_wb_addr;
    w_wb_data_next   = r_wb_data;
    w_wb_we_next     = r_wb_we;
    w_wb_sel_next    = r_wb_sel;
    w_wb_stb_next    = r_wb_stb;
    w_wb_cyc_next    = r_wb_cyc;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_err_next   = r_rsp_err;
    w_rsp_data_next  = r_rsp_data;
`ifdef WB_MASTER_TIMEOUT_EN
    w_wait_cnt_next  = r_wait_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        // ack/err arriving here are stray and deliberately ignored.
        if (bus.req_valid_i) begin
          w_wb_addr_next = bus.req_addr_i;
          w_wb_data_next = bus.req_data_i;
          w_wb_we_next   = bus.req_we_i;
          w_wb_sel_next  = bus.req_sel_i;
          w_wb_cyc_next  = 1'b1;
          w_wb_stb_next  = 1'b1;
          w_state_next   = S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          w_wait_cnt_next = '0;
`endif
        end
      end

      S_BUS: begin
        // Error has priority over a simultaneous ack; both beat the timeout.
        if (bus.wb_err_i) begin
          w_wb_cyc_next    = 1'b0;
          w_wb_stb_next    = 1'b0;
          w_wb_we_next     = 1'b0;
          w_rsp_err_next   = 1'b1;
          w_rsp_data_next  = '0;
          w_rsp_valid_next = 1'b1;
          w_state_next     = S_RESP;
        end else if (bus.wb_ack_i) begin
          w_wb_cyc_next    = 1'b0;
          w_wb_stb_next    = 1'b0;
          w_wb_we_next     = 1'b0;
          w_rsp_err_next   = 1'b0;
          w_rsp_data_next  = r_wb_we ? '0 : bus.wb_data_i;
          w_rsp_valid_next = 1'b1;
          w_state_next     = S_RESP;
        end else if (w_timeout) begin
          w_wb_cyc_next    = 1'b0;
          w_wb_stb_next    = 1'b0;
          w_wb_we_next     = 1'b0;
          w_rsp_err_next   = 1'b1;
          w_rsp_data_next  = '0;
          w_rsp_valid_next = 1'b1;
          w_state_next     = S_RESP;
        end else begin
`ifdef WB_MASTER_TIMEOUT_EN
          w_wait_cnt_next = r_wait_cnt + 1'b1;
`endif
        end
      end

      S_RESP: begin
        // Response stays frozen until consumed; IDLE then costs one cycle
        // before the next request can be taken.
        if (bus.rsp_ready_i) begin
          w_rsp_valid_next = 1'b0;
          w_state_next     = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_master_port.sv
// Directed plus randomized bench for wb_master_port.
// Expected responses and timing come from the transaction-level rules:
// a cycle lasts (ack delay + 1) clocks, errors return data 0 with err set,
// writes return data 0, reads return the slave's data.
module tb_wb_master_port;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  always #5 clk_i = ~clk_i;

  wb_master_port_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW)) bus ();

  wb_master_port #(
    .WB_DATA_WIDTH (DW),
    .WB_ADDR_WIDTH (AW),
    .WB_SEL_WIDTH  (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rule for the response: mode 0 = ack, 1 = err, 2 = ack+err.
  function automatic logic [32:0] ref_rsp(input logic we, input int mode, input logic [31:0] rdata);
    if (mode != 0) return {1'b1, 32'h0};
    if (we)        return {1'b0, 32'h0};
    return {1'b0, rdata};
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input int delay, input logic [31:0] rdata,
                         input int mode, input int bp, input bit hold_valid);
    logic [32:0] exp_rsp;
    int          cyc_cnt;
    bit          stable;
    exp_rsp = ref_rsp(we, mode, rdata);
    check("idle_ready", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.req_we_i    = we;
    bus.req_sel_i   = sel;
    bus.rsp_ready_i = 1'b0;
    tick();
    if (hold_valid) begin
      // keep valid high with a different payload; it must be ignored
      bus.req_addr_i = $urandom;
      bus.req_data_i = $urandom;
      bus.req_we_i   = ~we;
    end else begin
      bus.req_valid_i = 1'b0;
    end
    check("acc_cyc", bus.wb_cyc_o, 1);
    check("acc_stb", bus.wb_stb_o, 1);
    check("acc_addr", bus.wb_addr_o, addr);
    check("acc_data", bus.wb_data_o, data);
    check("acc_we", bus.wb_we_o, we);
    check("acc_sel", bus.wb_sel_o, sel);
    check("bus_ready", bus.req_ready_o, 0);
    cyc_cnt = 0;
    stable  = 1'b1;
    for (int c = 0; c <= delay; c++) begin
      if (c == delay) begin
        bus.wb_ack_i  = (mode != 1);
        bus.wb_err_i  = (mode != 0);
        bus.wb_data_i = rdata;
      end else begin
        bus.wb_ack_i  = 1'b0;
        bus.wb_err_i  = 1'b0;
        bus.wb_data_i = $urandom;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o) cyc_cnt++;
      if (bus.wb_addr_o !== addr || bus.wb_data_o !== data || bus.wb_we_o !== we ||
          bus.wb_sel_o !== sel || bus.rsp_valid_o !== 1'b0) stable = 1'b0;
      tick();
    end
    bus.wb_ack_i  = 1'b0;
    bus.wb_err_i  = 1'b0;
    bus.wb_data_i = $urandom;
    check("cyc_len", cyc_cnt, delay + 1);
    check("bus_stable", {31'b0, stable}, 1);
    check("end_cyc", bus.wb_cyc_o, 0);
    check("end_stb", bus.wb_stb_o, 0);
    check("end_we", bus.wb_we_o, 0);
    check("rsp_valid", bus.rsp_valid_o, 1);
    check("rsp_err", bus.rsp_err_o, exp_rsp[32]);
    check("rsp_data", bus.rsp_data_o, exp_rsp[31:0]);
    stable = 1'b1;
    for (int b = 0; b < bp; b++) begin
      bus.wb_ack_i = 1'($urandom_range(0, 1));  // stray acks must not matter
      tick();
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== exp_rsp[32] ||
          bus.rsp_data_o !== exp_rsp[31:0] || bus.req_ready_o !== 1'b0 ||
          bus.wb_cyc_o !== 1'b0) stable = 1'b0;
    end
    bus.wb_ack_i = 1'b0;
    check("bp_stable", {31'b0, stable}, 1);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("hs_valid", bus.rsp_valid_o, 0);
    check("hs_ready", bus.req_ready_o, 1);
    check("hs_cyc", bus.wb_cyc_o, 0);
    n_txn++;
    $display("txn %0d: we=%0d addr=0x%08h data=0x%08h sel=0x%0h delay=%0d mode=%0d bp=%0d -> err=%0d rdata=0x%08h",
             n_txn, we, addr, data, sel, delay, mode, bp, bus.rsp_err_o, bus.rsp_data_o);
  endtask

  initial begin
    int  cnt;
    bit  ok;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_we_i    = 1'b0;
    bus.req_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;
    bus.wb_data_i   = '0;

    // reset state
    tick();
    tick();
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_stb", bus.wb_stb_o, 0);
    check("rst_we", bus.wb_we_o, 0);
    check("rst_addr", bus.wb_addr_o, 0);
    check("rst_wdata", bus.wb_data_o, 0);
    check("rst_sel", bus.wb_sel_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_err", bus.rsp_err_o, 0);
    check("rst_rsp_data", bus.rsp_data_o, 0);
    rst_i = 1'b0;
    tick();
    check("rst_ready", bus.req_ready_o, 1);

    // write to a registered-ack slave
    run_txn(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1, 32'h12345678, 0, 0, 1'b0);
    // read acked 3 cycles after stb
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, 3, 32'h0000002A, 0, 0, 1'b0);
    // backpressure with the next request already waiting
    run_txn(1'b0, 32'h20, 32'h0, 4'hF, 1, 32'hCAFEF00D, 0, 5, 1'b1);
    // combinational-ack slave, accepted on the edge right after the idle cycle
    run_txn(1'b1, 32'h24, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 0, 0, 1'b0);
    // ack and err together on a read
    run_txn(1'b0, 32'h30, 32'h0, 4'hF, 2, 32'hFFFFFFFF, 2, 1, 1'b0);

    // stray ack/err while idle
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    tick();
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    check("idle_stray_cyc", bus.wb_cyc_o, 0);
    check("idle_stray_valid", bus.rsp_valid_o, 0);
    check("idle_stray_ready", bus.req_ready_o, 1);

    // randomized transactions
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    // slave that never answers
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'h40;
    tick();
    bus.req_valid_i = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt = 0;
    for (int c = 0; c < 100 && bus.wb_cyc_o === 1'b1; c++) begin
      cnt++;
      tick();
    end
    check("to_cyc_len", cnt, TO);
    check("to_valid", bus.rsp_valid_o, 1);
    check("to_err", bus.rsp_err_o, 1);
    check("to_data", bus.rsp_data_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("to_hs_ready", bus.req_ready_o, 1);
`else
    ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) ok = 1'b0;
      tick();
    end
    check("noto_wait", {31'b0, ok}, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    check("noto_recover", bus.req_ready_o, 1);
`endif

    // reset two cycles into BUS
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h50;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    check("pre_rst_cyc", bus.wb_cyc_o, 1);
    rst_i = 1'b1;
    #1;
    check("rst_bus_cyc", bus.wb_cyc_o, 0);
    check("rst_bus_stb", bus.wb_stb_o, 0);
    check("rst_bus_valid", bus.rsp_valid_o, 0);
    tick();
    tick();
    rst_i = 1'b0;
    bus.wb_ack_i = 1'b1;  // late ack for the abandoned cycle
    tick();
    bus.wb_ack_i = 1'b0;
    check("post_rst_ready", bus.req_ready_o, 1);
    check("post_rst_valid", bus.rsp_valid_o, 0);

    // reset while a response is pending
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    tick();
    bus.req_valid_i = 1'b0;
    bus.wb_ack_i    = 1'b1;
    bus.wb_data_i   = 32'h77;
    tick();
    bus.wb_ack_i    = 1'b0;
    check("resp_pending", bus.rsp_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("rst_resp_valid", bus.rsp_valid_o, 0);
    check("rst_resp_data", bus.rsp_data_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("rst_resp_ready", bus.req_ready_o, 1);

    // normal operation after reset
    run_txn(1'b0, 32'h60, 32'h0, 4'h1, 1, 32'h0BADF00D, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
- Single-outstanding Wishbone classic initiator. Converts a valid/ready request stream into one Wishbone cycle, then returns a valid/ready response.
- Lets the core-side debug/test logic and small DMA helpers drive memory-mapped slaves such as the timer and UART. Register-level access only: no bursts, no pipelining.

Parameters:
- WB_DATA_WIDTH, 32, Wishbone and request/response data width.
- WB_ADDR_WIDTH, 32, Wishbone and request address width.
- WB_SEL_WIDTH, 4, byte-select width (WB_DATA_WIDTH/8).
- TIMEOUT_CYCLES, 255, bus-wait limit in cycles. Used only when WB_MASTER_TIMEOUT_EN is defined. Must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_addr_i  in  WB_ADDR_WIDTH  target address
- req_data_i  in  WB_DATA_WIDTH  write data
- req_we_i  in  1  1 = write, 0 = read
- req_sel_i  in  WB_SEL_WIDTH  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  WB_DATA_WIDTH  read data (0 for writes and errors)
- rsp_err_o  out  1  transaction ended in error or timeout
- wb_addr_o  out  WB_ADDR_WIDTH  Wishbone address
- wb_data_o  out  WB_DATA_WIDTH  Wishbone write data
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  WB_SEL_WIDTH  Wishbone byte selects
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error (tie 0 for slaves without it)
- wb_data_i  in  WB_DATA_WIDTH  Wishbone read data

Behaviour:
- One clock, clk_i. rst_i is asynchronous and active-high.
- All outputs are registered. req_ready_o is decoded from state.
- Reset values:
  - state = IDLE.
  - wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o = 0.
  - wb_addr_o, wb_data_o, wb_sel_o, rsp_data_o = 0.
  - req_ready_o = 1 once rst_i is low.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o = 1.
  - On the edge where req_valid_i & req_ready_o, latch addr/data/we/sel onto the wb_* outputs, set wb_cyc_o = wb_stb_o = 1, go to BUS.
  - Wishbone lines are therefore active from the cycle after acceptance.
- BUS:
  - req_ready_o = 0. Hold all wb_* outputs stable.
  - On an edge with wb_err_i = 1: clear cyc/stb/we, rsp_err_o = 1, rsp_data_o = 0, rsp_valid_o = 1, go to RESP. Err wins over a simultaneous ack.
  - Else on an edge with wb_ack_i = 1: clear cyc/stb/we, rsp_err_o = 0, rsp_valid_o = 1, go to RESP. rsp_data_o = wb_data_i if a read, 0 if a write.
  - Minimum cycle length is 1 cycle of cyc/stb, for a slave acking combinationally.
  - With a registered-ack slave, cyc/stb are high 2 cycles and rsp_valid_o rises 2 cycles after acceptance.
- RESP:
  - req_ready_o = 0. rsp_* held stable while rsp_ready_i = 0.
  - On rsp_valid_o & rsp_ready_i: clear rsp_valid_o, go to IDLE.
  - A new request is accepted no earlier than the following cycle (one idle cycle between transactions).
- Boundary conditions:
  - wb_ack_i or wb_err_i seen in IDLE or RESP is ignored; no state or output change.
  - req_valid_i outside IDLE is ignored; the requester holds it per valid/ready rules.
  - Reset mid-BUS drops cyc/stb immediately (asynchronously) and abandons the transaction; no response is produced.
  - Reset mid-RESP discards the pending response.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle without ack/err.
  - On the edge where the counter reaches TIMEOUT_CYCLES-1 with no ack/err, cyc/stb drop and RESP is entered with rsp_err_o = 1, rsp_data_o = 0. cyc is therefore high exactly TIMEOUT_CYCLES cycles.
  - An ack or err on that same edge takes priority over the timeout.
- Not defined: no counter logic; BUS waits indefinitely for ack/err.

Test Plan:
- Write, registered-ack slave: req addr 0x08, data 0xDEADBEEF, sel 0xF, we 1.
  -> wb_addr_o = 0x08, wb_data_o = 0xDEADBEEF, we/cyc/stb high 2 cycles.
  -> rsp_valid_o 2 cycles after acceptance, rsp_err_o 0, rsp_data_o 0.
- Read, slave acks 3 cycles after stb with wb_data_i = 0x0000002A
  -> cyc high 4 cycles, wb_we_o 0, rsp_data_o = 0x2A, rsp_err_o 0.
- Backpressure: rsp_ready_i low 5 cycles after rsp_valid_o, req_valid_i held high
  -> rsp_valid_o/rsp_data_o stable, req_ready_o 0, no wb_cyc_o.
  -> Next request starts 2 cycles after rsp_ready_i rises.
- wb_ack_i and wb_err_i high in the same cycle on a read -> rsp_err_o 1, rsp_data_o 0.
- Timeout, macro on, TIMEOUT_CYCLES = 16, slave never acks
  -> cyc high exactly 16 cycles, then rsp_valid_o 1 with rsp_err_o 1.
- Timeout, macro off, slave never acks -> cyc stays high 1000 cycles, no response.
- rst_i pulsed 2 cycles into BUS -> wb_cyc_o/wb_stb_o 0 before the next edge, rsp_valid_o 0, req_ready_o 1 after release.
